user_io_counter: RTL

USER_IO_COUNTER -- requirements
Module: user_io_counter

---
 rtl/user_io_counter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/user_io_counter.sv
// -----------------------------------------------------------------------------
// user_io_counter
//   Wishbone-controlled up/down counter with a programmable prescaler,
//   compare match and wrap detection, driven out to user GPIO pads.
//
// Register map (word offsets inside a 32-byte window at BASE_ADDR):
//   0x00 CTRL     bit0 EN, bit1 DOWN, bit2 OE, bit3 IRQ_EN
//   0x04 COUNT    counter value (write loads the counter)
//   0x08 PRESCALE bits [15:0]
//   0x0C COMPARE  bits [WIDTH-1:0]
//   0x10 STATUS   bit0 MATCH, bit1 WRAP (sticky, write-1-to-clear)
//   0x14-0x1C     read as 0, writes acknowledged and ignored
//
// Ports:
//   wb_clk_i            single clock, rising edge
//   resetb              asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]      byte lane selects for writes
//   wbs_adr_i[31:0]     address
//   wbs_dat_i[31:0]     write data
//   wbs_ack_o           registered one-cycle acknowledge
//   wbs_dat_o[31:0]     read data, valid with ack, 0 otherwise
//   io_out[WIDTH-1:0]   counter value to the pads
//   io_oeb[WIDTH-1:0]   active-low pad output enables
//   irq_o               IRQ_EN & (MATCH | WRAP)
// -----------------------------------------------------------------------------
module user_io_counter #(
    parameter int          WIDTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             resetb,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] io_oeb,
    output logic             irq_o
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_COUNT    = 3'd1;
    localparam logic [2:0] OFF_PRESCALE = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    // Architectural state
    logic [3:0]       ctrl_reg;
    logic [WIDTH-1:0] count_reg;
    logic [15:0]      prescale_reg;
    logic [WIDTH-1:0] compare_reg;
    logic [1:0]       status_reg;
    logic [15:0]      pre_cnt_reg;
    logic             ack_reg;
    logic [31:0]      dat_reg;

    // Next-state / decode
    logic [WIDTH-1:0] count_next;
    logic [1:0]       status_next;
    logic [15:0]      pre_cnt_next;
    logic [WIDTH-1:0] count_step;
    logic [1:0]       status_w1c;
    logic             match_set;
    logic             wrap_set;
    logic             blk_sel;
    logic             xfer;
    logic             wr_en;
    logic             rd_en;
    logic             tick;
    logic [2:0]       reg_off;
    logic [31:0]      byte_mask;
    logic [31:0]      reg_rdata;
    logic [31:0]      wdata_merged;
    logic [31:0]      count_ext;
    logic [31:0]      compare_ext;

    logic en;
    logic down;
    assign en   = ctrl_reg[0];
    assign down = ctrl_reg[1];

    // ---------------------------------------------------------------
    // Bus decode. A transfer is taken only while ack is low, so a held
    // strobe is served every second cycle.
    // ---------------------------------------------------------------
    assign blk_sel = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign xfer    = blk_sel & ~ack_reg;
    assign wr_en   = xfer & wbs_we_i;
    assign rd_en   = xfer & ~wbs_we_i;
    assign reg_off = wbs_adr_i[4:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_mask[8*gi +: 8] = {8{wbs_sel_i[gi]}};
        end
    endgenerate

    // Current value of the addressed register, zero-extended. Also serves
    // as the "old" value for byte-lane merging on writes.
    always_comb begin
        count_ext                = '0;
        count_ext[WIDTH-1:0]     = count_reg;
        compare_ext              = '0;
        compare_ext[WIDTH-1:0]   = compare_reg;
        case (reg_off)
            OFF_CTRL:     reg_rdata = {28'd0, ctrl_reg};
            OFF_COUNT:    reg_rdata = count_ext;
            OFF_PRESCALE: reg_rdata = {16'd0, prescale_reg};
            OFF_COMPARE:  reg_rdata = compare_ext;
            OFF_STATUS:   reg_rdata = {30'd0, status_reg};
            default:      reg_rdata = 32'd0;
        endcase
    end

    assign wdata_merged = (reg_rdata & ~byte_mask) | (wbs_dat_i & byte_mask);

    // ---------------------------------------------------------------
    // Prescaler and counter
    // ---------------------------------------------------------------
    assign tick       = en & (pre_cnt_reg == prescale_reg);
    assign count_step = down ? (count_reg - CNT_ONE) : (count_reg + CNT_ONE);

    always_comb begin
        if (wr_en && reg_off == OFF_PRESCALE) begin
            pre_cnt_next = 16'd0;
        end else if (!en || tick) begin
            pre_cnt_next = 16'd0;
        end else begin
            pre_cnt_next = pre_cnt_reg + 16'd1;
        end
    end

    // A COUNT write takes precedence over the tick in the same cycle; the
    // step is dropped and a load never reports a wrap.
    always_comb begin
        count_next = count_reg;
        match_set  = 1'b0;
        wrap_set   = 1'b0;
        if (wr_en && reg_off == OFF_COUNT) begin
            count_next = wdata_merged[WIDTH-1:0];
            match_set  = (wdata_merged[WIDTH-1:0] == compare_reg);
        end else if (tick) begin
            count_next = count_step;
            match_set  = (count_step == compare_reg);
            wrap_set   = down ? (count_reg == '0) : (&count_reg);
        end
    end

    // Clear first, then set, so a set in the same cycle wins.
    always_comb begin
        status_w1c = 2'b00;
        if (wr_en && reg_off == OFF_STATUS && wbs_sel_i[0]) begin
            status_w1c = wbs_dat_i[1:0];
        end
        status_next = (status_reg & ~status_w1c) | {wrap_set, match_set};
    end

    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            ctrl_reg     <= '0;
            count_reg    <= '0;
            prescale_reg <= '0;
            compare_reg  <= '0;
            status_reg   <= '0;
            pre_cnt_reg  <= '0;
            ack_reg      <= 1'b0;
            dat_reg      <= '0;
        end else begin
            ack_reg     <= xfer;
            dat_reg     <= rd_en ? reg_rdata : 32'd0;
            count_reg   <= count_next;
            status_reg  <= status_next;
            pre_cnt_reg <= pre_cnt_next;
            if (wr_en && reg_off == OFF_CTRL) begin
                ctrl_reg <= wdata_merged[3:0];
            end
            if (wr_en && reg_off == OFF_PRESCALE) begin
                prescale_reg <= wdata_merged[15:0];
            end
            if (wr_en && reg_off == OFF_COMPARE) begin
                compare_reg <= wdata_merged[WIDTH-1:0];
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign io_out    = count_reg;
    assign io_oeb    = {WIDTH{~ctrl_reg[2]}};
    assign irq_o     = ctrl_reg[3] & (|status_reg);

    // Address byte offset and the upper merge bits are not needed.
    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_adr_i[1:0], wdata_merged};

endmodule
